red_barrett_pipe: RTL
=====================

Name: red_barrett_pipe

Overview:
- Parametrised, pipelined Barrett modular reducer. Generalises the combinational Kyber reducer to any odd modulus Q, e.g. Kyber 3329 or Dilithium 8380417.
- Accepts the full input range 0..2^K-1, where K = 2*W, not only products below Q^2.
- Has a valid/ready streaming interface with backpressure and a sideband tag.
- Sits between the NTT butterfly multipliers and the coefficient buffers.

Parameters:
- Q, 3329, modulus; odd, 2 < Q < 2^W.
- W, 12, result width; W = $clog2(Q).
- K, 2*W, input width and Barrett shift amount.
- M, floor(2^K / Q), Barrett constant; computed in the package, never overridden by hand (5039 for Kyber).
- TAG_W, 4, sideband tag width; carried unchanged alongside the data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  K  value to reduce, 0..2^K-1.
- in_tag  in  TAG_W  sideband, returned with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  W  in_data mod Q, always in 0..Q-1.
- out_tag  out  TAG_W  tag of the sample in out_data.

Behaviour:
- Reset: synchronous, sampled when rst_n=0 at a clock edge. Clears v1, v2, v3; out_valid=0; in_ready=1 after reset; out_data and out_tag read 0. Datapath registers need no reset but are zeroed for clean waveforms.
- Transfer rule: a transfer occurs when valid && ready are both high at a clock edge. in_ready never depends on in_valid (no combinational loop). out_valid, out_data and out_tag hold stable until out_ready=1.
- Stage 1 (v1): capture x=in_data and the tag; compute p1 = x*M (K + W + 1 bits, full width, no truncation).
- Stage 2 (v2): qe = p1 >> K; r = x - qe*Q, computed to W+2 bits. Invariant: 0 <= r < 3Q, because qe underestimates floor(x/Q) by at most 2 for x < 2^K.
- Stage 3 (v3): r1 = (r >= Q) ? r-Q : r; out = (r1 >= Q) ? r1-Q : r1. Uses two cascaded conditional subtracts; the result is registered to out_data.
- Latency: exactly 3 cycles from input transfer to out_valid while out_ready=1.
- Throughput: 1 sample per cycle sustained.
- Stall logic: stage i advances when v_i=0 or stage i+1 advances; stage 3 advances when out_ready=1 or v3=0; in_ready = stage 1 advances. All stages hold when out_ready=0 and the pipe is full; no sample is lost or duplicated.
- Simultaneous accept and emit while full: allowed, with no bubble.
- Reset mid-stream: all in-flight samples are discarded; the first output after reset belongs to the first post-reset input.
- Ordering: strictly in order; out_tag always matches its own data.

Decomposition:
- Package red_pkg:
  - constants KYBER_Q=3329 and DILITHIUM_Q=8380417;
  - function barrett_m(q, k) returning floor(2^k/q);
  - function clog2-based width helpers.
- Sub-module cond_sub_q (parameters Q, W): combinational a -> (a>=Q ? a-Q : a). Instantiated twice in stage 3; it replaces the unfinished half_sub chain of the combinational reducer.

Test Plan:
- Q=3329, single sample in_data=11075584 (3328^2), tag=5 -> out_data=1, tag=5, exactly 3 cycles later.
- Q=3329 boundaries: inputs 0, 3328, 3329, 6658, 16777215 -> outputs 0, 3328, 0, 0, 2384. In the 16777215 case r=5713 before correction, so exactly one conditional subtract fires.
- Q=8380417, W=23: inputs (Q-1)^2 -> 1, Q -> 0, 2^46-1 -> (2^46-1) mod Q, checked against the scoreboard model.
- Backpressure: stream 20 random samples back to back, out_ready=0 for cycles 4..9 -> in_ready=0 once 3 samples are held; output stays stable; all 20 results arrive in order, correct, with no gaps after release.
- Reset mid-stream: rst_n=0 for 1 cycle with 3 samples in flight -> out_valid=0 the next cycle and those samples never appear; a new sample then returns correctly after 3 cycles.
- Random soak: 10^5 random inputs 0..2^K-1, random in_valid/out_ready -> every output equals x mod Q, < Q, with the matching tag.

Source files
------------

// File: rtl/red_pkg.sv
// Shared constants and parameter helpers for the Barrett modular reducers.
package red_pkg;

  localparam int unsigned KYBER_Q     = 3329;
  localparam int unsigned DILITHIUM_Q = 8380417;

  // floor(2^k / q); k may reach 46 for Dilithium, so work in 64 bits.
  function automatic longint unsigned barrett_m(input int unsigned q, input int unsigned k);
    return (64'd1 << k) / 64'(q);
  endfunction

  function automatic int unsigned red_w(input int unsigned q);
    return $clog2(q);
  endfunction

  function automatic int unsigned red_k(input int unsigned q);
    return 2 * $clog2(q);
  endfunction

endpackage

// File: rtl/red_barrett_pipe_cond_sub_q.sv
// Single conditional subtract of the modulus: y = (a >= Q) ? a - Q : a.
module cond_sub_q #(
  parameter int unsigned Q = 3329,
  parameter int unsigned W = 12
) (
  input  logic [W+1:0] a,
  output logic [W+1:0] y
);

  localparam logic [W+1:0] QX = (W+2)'(Q);

  always_comb begin
    y = a;
    if (a >= QX) begin
      y = a - QX;
    end
  end

endmodule

// File: rtl/red_barrett_pipe.sv
// Three-stage pipelined Barrett reducer with valid/ready handshake and sideband tag.
module red_barrett_pipe
  import red_pkg::*;
#(
  parameter int unsigned Q     = KYBER_Q,
  parameter int unsigned W     = red_w(Q),
  parameter int unsigned K     = 2 * W,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned  PW = K + W + 1;
  localparam logic [W:0]   M  = (W+1)'(barrett_m(Q, K));
  localparam logic [K-1:0] QK = K'(Q);

  logic             v1_q, v2_q, v3_q;
  logic             adv1, adv2, adv3;
  logic [K-1:0]     x1_q;
  logic [PW-1:0]    p1_d, p1_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
  logic [W:0]       qe;
  logic [K-1:0]     qq;
  logic [W+1:0]     r2_d, r2_q;
  logic [W+1:0]     r1, r0;
  logic [W-1:0]     out_d, out_q;

  // A stage may load when it is empty or its successor is moving on.
  always_comb begin
    adv3 = !v3_q || out_ready;
    adv2 = !v2_q || adv3;
    adv1 = !v1_q || adv2;
  end

  assign in_ready = adv1;

  assign p1_d = PW'(in_data) * PW'(M);
  assign qe   = (W+1)'(p1_q >> K);
  assign qq   = K'(qe) * QK;
  // True difference lies in [0, 3Q), so the low W+2 bits are exact.
  assign r2_d = (W+2)'(x1_q - qq);

  cond_sub_q #(.Q(Q), .W(W)) u_sub0 (.a(r2_q), .y(r1));
  cond_sub_q #(.Q(Q), .W(W)) u_sub1 (.a(r1),   .y(r0));

  assign out_d = W'(r0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      x1_q   <= '0;
      p1_q   <= '0;
      tag1_q <= '0;
      r2_q   <= '0;
      tag2_q <= '0;
      out_q  <= '0;
      tag3_q <= '0;
    end else begin
      if (adv1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          x1_q   <= in_data;
          p1_q   <= p1_d;
          tag1_q <= in_tag;
        end
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          r2_q   <= r2_d;
          tag2_q <= tag1_q;
        end
      end
      if (adv3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          out_q  <= out_d;
          tag3_q <= tag2_q;
        end
      end
    end
  end

  assign out_valid = v3_q;
  assign out_data  = out_q;
  assign out_tag   = tag3_q;

endmodule
